pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline stage register for the processor pipeline. It is the generalised replacement for the fixed-field inter-stage latches.
- Carries a control bundle and a data bundle of configurable width.
- Adds a valid/ready handshake, stall (hold), flush (bubble insertion), an optional 2-entry skid buffer and a saturating stall-cycle counter.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 102 ++++++++++
 tb/tb_pipe_stage_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register carrying a control and a data bundle,
// with stall, flush, optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 8,
    parameter int CNT_W   = 16,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic              acc;
    logic              adv;

    assign adv = main_valid & ready_i & ~stall_i;

    // With the skid entry, ready_o comes straight from a flop so upstream never
    // sees a combinational path from ready_i/stall_i.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign ready_o = ~skid_valid;
        end else begin : g_comb_ready
            assign ready_o = ~main_valid | (ready_i & ~stall_i);
        end
    endgenerate

    assign acc = valid_i & ready_o;

    // NOTE: every register here uses <= so all of them sample the pre-edge
    // values of each other; blocking assignments would create ordering bugs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush_i) begin
            // data bundle is deliberately left untouched on a flush
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (adv) begin
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || adv) begin
            if (acc) begin
                main_valid <= 1'b1;
                main_ctrl  <= ctrl_i;
                main_data  <= data_i;
            end else if (adv) begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
        end else if (acc && SKID_EN) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= ctrl_i;
            skid_data  <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            stall_cnt <= '0;
        end else if (main_valid && !adv && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign valid_o     = main_valid;
    assign ctrl_o      = main_valid ? main_ctrl : '0;
    assign data_o      = main_data;
    assign occ_o       = {1'b0, main_valid} + {1'b0, skid_valid};
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: default, CNT_W=4 and
// SKID_EN=0 instances share one stimulus stream; each section checks one of them.
module tb_pipe_stage_reg;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, stall_i, valid_i, ready_i, cnt_clr_i;
    logic [7:0]  ctrl_i;
    logic [31:0] data_i;

    logic        d_ready, d_valid;
    logic [7:0]  d_ctrl;
    logic [31:0] d_data;
    logic [1:0]  d_occ;
    logic [15:0] d_cnt;

    logic        c_ready, c_valid;
    logic [7:0]  c_ctrl;
    logic [31:0] c_data;
    logic [1:0]  c_occ;
    logic [3:0]  c_cnt;

    logic        n_ready, n_valid;
    logic [7:0]  n_ctrl;
    logic [31:0] n_data;
    logic [1:0]  n_occ;
    logic [15:0] n_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_reg u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
        .valid_i(valid_i), .ready_o(d_ready), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(d_valid), .ready_i(ready_i), .ctrl_o(d_ctrl), .data_o(d_data),
        .occ_o(d_occ), .cnt_clr_i(cnt_clr_i), .stall_cnt_o(d_cnt)
    );

    pipe_stage_reg #(.CNT_W(4)) u_cnt4 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
        .valid_i(valid_i), .ready_o(c_ready), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(c_valid), .ready_i(ready_i), .ctrl_o(c_ctrl), .data_o(c_data),
        .occ_o(c_occ), .cnt_clr_i(cnt_clr_i), .stall_cnt_o(c_cnt)
    );

    pipe_stage_reg #(.SKID_EN(1'b0)) u_noskid (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
        .valid_i(valid_i), .ready_o(n_ready), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(n_valid), .ready_i(ready_i), .ctrl_o(n_ctrl), .data_o(n_data),
        .occ_o(n_occ), .cnt_clr_i(cnt_clr_i), .stall_cnt_o(n_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d);
        valid_i = v;
        ctrl_i  = c;
        data_i  = d;
    endtask

    task automatic chk_d(input string tag, input logic v, input logic [7:0] c,
                         input logic [31:0] d, input logic [1:0] o);
        check({tag, "_valid"}, d_valid, v);
        check({tag, "_ctrl"},  d_ctrl,  c);
        check({tag, "_data"},  d_data,  d);
        check({tag, "_occ"},   d_occ,   o);
    endtask

    // A single-register stage must never report two entries.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0) check("ns_occ_le1", n_occ <= 2'd1, 1'b1);
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0; ready_i = 1'b0; cnt_clr_i = 1'b0;
        drive(1'b0, 8'h00, 32'h0);
        tick(); tick();
        rst_i = 1'b0;
        chk_d("rst", 1'b0, 8'h00, 32'h0, 2'd0);
        check("rst_cnt", d_cnt, 16'd0);
        check("rst_ready", d_ready, 1'b1);

        // 1: back-to-back stream
        ready_i = 1'b1;
        drive(1'b1, 8'h01, 32'h10); tick(); chk_d("s0", 1'b1, 8'h01, 32'h10, 2'd1);
        drive(1'b1, 8'h01, 32'h11); tick(); chk_d("s1", 1'b1, 8'h01, 32'h11, 2'd1);
        drive(1'b1, 8'h01, 32'h12); tick(); chk_d("s2", 1'b1, 8'h01, 32'h12, 2'd1);
        drive(1'b0, 8'h00, 32'h0);  tick(); chk_d("s_end", 1'b0, 8'h00, 32'h12, 2'd0);
        check("s_cnt", d_cnt, 16'd0);

        // 2: backpressure fills the skid entry
        ready_i = 1'b0;
        drive(1'b1, 8'h01, 32'hA0); tick(); chk_d("bp0", 1'b1, 8'h01, 32'hA0, 2'd1);
        check("bp0_ready", d_ready, 1'b1);
        drive(1'b1, 8'h01, 32'hA1); tick(); chk_d("bp1", 1'b1, 8'h01, 32'hA0, 2'd2);
        check("bp1_ready", d_ready, 1'b0);
        drive(1'b1, 8'h01, 32'hA2); tick(); tick();
        chk_d("bp_hold", 1'b1, 8'h01, 32'hA0, 2'd2);
        check("bp_hold_cnt", d_cnt, 16'd3);
        ready_i = 1'b1;
        tick(); chk_d("bp_out1", 1'b1, 8'h01, 32'hA1, 2'd1);
        check("bp_out1_ready", d_ready, 1'b1);
        tick(); chk_d("bp_out2", 1'b1, 8'h01, 32'hA2, 2'd1);
        drive(1'b0, 8'h00, 32'h0);
        tick(); chk_d("bp_end", 1'b0, 8'h00, 32'hA2, 2'd0);
        check("bp_cnt", d_cnt, 16'd3);
        cnt_clr_i = 1'b1; tick(); cnt_clr_i = 1'b0;
        check("clr_cnt", d_cnt, 16'd0);

        // 3: stall overrides ready_i
        ready_i = 1'b0;
        drive(1'b1, 8'h01, 32'h55); tick();
        drive(1'b0, 8'h00, 32'h0);
        ready_i = 1'b1; stall_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_d("stall", 1'b1, 8'h01, 32'h55, 2'd1);
            check("stall_cnt", d_cnt, 16'(i));
        end
        stall_i = 1'b0;
        tick(); chk_d("stall_end", 1'b0, 8'h00, 32'h55, 2'd0);

        // 4: flush of a full stage, then of an accepting stage, then reset
        ready_i = 1'b0;
        drive(1'b1, 8'hFF, 32'hB0); tick();
        drive(1'b1, 8'hFF, 32'hB1); tick();
        chk_d("fl_full", 1'b1, 8'hFF, 32'hB0, 2'd2);
        check("fl_full_cnt", d_cnt, 16'd4);
        flush_i = 1'b1; drive(1'b1, 8'hFF, 32'hB2); tick();
        flush_i = 1'b0; drive(1'b0, 8'h00, 32'h0);
        chk_d("fl", 1'b0, 8'h00, 32'hB0, 2'd0);
        check("fl_cnt_kept", d_cnt, 16'd5);
        check("fl_ready", d_ready, 1'b1);
        tick(); chk_d("fl_after", 1'b0, 8'h00, 32'hB0, 2'd0);
        ready_i = 1'b1;
        drive(1'b1, 8'hFF, 32'hC0); tick(); chk_d("fl2_pre", 1'b1, 8'hFF, 32'hC0, 2'd1);
        flush_i = 1'b1; drive(1'b1, 8'hFF, 32'hC1); tick();
        flush_i = 1'b0; drive(1'b0, 8'h00, 32'h0);
        chk_d("fl2", 1'b0, 8'h00, 32'hC0, 2'd0);
        tick(); chk_d("fl2_after", 1'b0, 8'h00, 32'hC0, 2'd0);
        ready_i = 1'b0;
        drive(1'b1, 8'hFF, 32'hD0); tick();
        drive(1'b1, 8'hFF, 32'hD1); tick();
        chk_d("mr_full", 1'b1, 8'hFF, 32'hD0, 2'd2);
        rst_i = 1'b1; drive(1'b0, 8'h00, 32'h0); tick(); rst_i = 1'b0;
        chk_d("mr", 1'b0, 8'h00, 32'h0, 2'd0);
        check("mr_cnt", d_cnt, 16'd0);

        // 5: counter saturation on the 4-bit instance
        drive(1'b1, 8'h02, 32'hE0); tick();
        drive(1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt4", c_cnt, 4'd15);
        check("sat_cnt16", d_cnt, 16'd20);
        check("sat_valid", c_valid, 1'b1);
        cnt_clr_i = 1'b1; tick(); cnt_clr_i = 1'b0;
        check("sat_clr4", c_cnt, 4'd0);
        check("sat_clr16", d_cnt, 16'd0);
        tick();
        check("sat_resume", c_cnt, 4'd1);
        ready_i = 1'b1; tick();
        check("sat_drain", c_valid, 1'b0);

        // 6: single-register instance
        rst_i = 1'b1; ready_i = 1'b0; tick(); rst_i = 1'b0;
        drive(1'b1, 8'h03, 32'hF0); #1;
        check("ns_ready_empty", n_ready, 1'b1);
        tick();
        check("ns_f0", n_data, 32'hF0);
        check("ns_f0_valid", n_valid, 1'b1);
        drive(1'b1, 8'h03, 32'hF1); #1;
        check("ns_ready_bp", n_ready, 1'b0);
        tick();
        check("ns_hold", n_data, 32'hF0);
        check("ns_hold_occ", n_occ, 2'd1);
        ready_i = 1'b1; #1;
        check("ns_ready_drain", n_ready, 1'b1);
        tick();
        check("ns_f1", n_data, 32'hF1);
        drive(1'b1, 8'h03, 32'hF2); tick();
        check("ns_f2", n_data, 32'hF2);
        check("ns_f2_ctrl", n_ctrl, 8'h03);
        stall_i = 1'b1; drive(1'b1, 8'h03, 32'hF3); #1;
        check("ns_ready_stall", n_ready, 1'b0);
        tick();
        check("ns_stall_hold", n_data, 32'hF2);
        stall_i = 1'b0; drive(1'b0, 8'h00, 32'h0); tick();
        check("ns_end_valid", n_valid, 1'b0);
        check("ns_end_ctrl", n_ctrl, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
